// File: rtl/tib_accept.sv
// tib_accept: edits UART RX bytes into the TIB, echoes them on TX, and hands the finished line to the interpreter.
module tib_accept #(
  parameter int TIB    = 'h0,
  parameter int TIB_SZ = 80,
  parameter int MSZ    = 8,
  parameter int ASZ    = 17
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en_i,
  input  logic           rx_vld_i,
  input  logic [7:0]     rx_dat_i,
  output logic           rx_rdy_o,
  output logic           tx_vld_o,
  output logic [7:0]     tx_dat_o,
  input  logic           tx_rdy_i,
  output logic           mb_we_o,
  output logic [ASZ-1:0] mb_ai_o,
  output logic [MSZ-1:0] mb_vi_o,
  input  logic           ack_i,
  output logic           done_o,
  output logic [7:0]     len_o,
  output logic           ovf_o,
  output logic           bsy_o
);
  typedef enum logic [3:0] {IDLE, RCV, WR, ECHO, BS1, BS2, BS3, TRM0, TRM1, DONE, HOLD} st_t;
  localparam logic [ASZ-1:0] BASE = ASZ'(TIB);
  localparam logic [7:0] LMAX = 8'(TIB_SZ - 2);
  st_t state_q;
  logic [7:0] len_q, tx_dat_q;
  logic ovf_q, done_q, rx_rdy_q, tx_vld_q, we_q;
  logic [ASZ-1:0] ai_q;
  logic [MSZ-1:0] vi_q;
  logic acc, prt, bsp, eol;
  logic [7:0] chr;
  logic [ASZ-1:0] adr;
  always_comb begin
    acc = state_q == RCV && rx_vld_i && rx_rdy_q;
    chr = rx_dat_i == 8'h09 ? 8'h20 : rx_dat_i;
    prt = chr >= 8'h20 && chr <= 8'h7e;
    bsp = rx_dat_i == 8'h08 || rx_dat_i == 8'h7f;
    eol = rx_dat_i == 8'h0d || rx_dat_i == 8'h0a;
    adr = BASE + ASZ'(len_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      len_q    <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      rx_rdy_q <= 1'b0;
      tx_vld_q <= 1'b0;
      tx_dat_q <= '0;
      we_q     <= 1'b0;
      ai_q     <= BASE;
      vi_q     <= '0;
    end else if (!en_i) begin
      state_q  <= IDLE;
      len_q    <= '0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
      rx_rdy_q <= 1'b0;
      tx_vld_q <= 1'b0;
      we_q     <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      we_q     <= 1'b0;
      // ready drops for the cycle after every accept, so at most one byte per classification
      rx_rdy_q <= state_q == RCV && !acc;
      case (state_q)
        IDLE: state_q <= RCV;
        RCV: if (acc) begin
          if (prt && len_q < LMAX) begin
            state_q  <= WR;
            we_q     <= 1'b1;
            ai_q     <= adr;
            vi_q     <= MSZ'(chr);
            tx_dat_q <= chr;
          end else if (prt) begin
            state_q  <= ECHO;
            ovf_q    <= 1'b1;
            tx_vld_q <= 1'b1;
            tx_dat_q <= 8'h07;
          end else if (bsp && len_q != 8'd0) begin
            state_q  <= BS1;
            len_q    <= len_q - 8'd1;
            tx_vld_q <= 1'b1;
            tx_dat_q <= 8'h08;
          end else if (eol) begin
            state_q <= TRM0;
            we_q    <= 1'b1;
            ai_q    <= adr;
            vi_q    <= MSZ'(8'h20);
          end
        end
        WR: begin
          state_q  <= ECHO;
          len_q    <= len_q + 8'd1;
          tx_vld_q <= 1'b1;
        end
        ECHO, BS3: if (tx_rdy_i) begin
          state_q  <= RCV;
          tx_vld_q <= 1'b0;
        end
        BS1: if (tx_rdy_i) begin
          state_q  <= BS2;
          tx_dat_q <= 8'h20;
        end
        BS2: if (tx_rdy_i) begin
          state_q  <= BS3;
          tx_dat_q <= 8'h08;
        end
        TRM0: begin
          state_q <= TRM1;
          we_q    <= 1'b1;
          ai_q    <= ai_q + ASZ'(1);
          vi_q    <= '0;
        end
        TRM1: begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end
        DONE: state_q <= HOLD;
        HOLD: if (ack_i) begin
          state_q <= RCV;
          len_q   <= '0;
          ovf_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  // a write already issued is killed in the same cycle that rst or en drop arrives
  assign mb_we_o  = we_q & en_i & ~rst;
  assign mb_ai_o  = ai_q;
  assign mb_vi_o  = vi_q;
  assign rx_rdy_o = rx_rdy_q;
  assign tx_vld_o = tx_vld_q;
  assign tx_dat_o = tx_dat_q;
  assign done_o   = done_q;
  assign len_o    = len_q;
  assign ovf_o    = ovf_q;
  assign bsy_o    = state_q != IDLE && state_q != RCV;
endmodule

// File: tb/tb_tib_accept.sv
// tb_tib_accept: scoreboard bench for tib_accept; echo, write and done expectations are queued as bytes are sent.
module tb_tib_accept;
  localparam int TIB = 'h40;
  localparam int TSZ = 8;
  logic clk = 0, rst = 1, en_i = 0, rx_vld_i = 0, tx_rdy_i = 1, ack_i = 0;
  logic [7:0] rx_dat_i = 0;
  logic rx_rdy_o, tx_vld_o, mb_we_o, done_o, ovf_o, bsy_o;
  logic [7:0] tx_dat_o, len_o, mb_vi_o;
  logic [16:0] mb_ai_o;
  int total = 0, bad = 0, m_len = 0, m_ovf = 0;
  logic [31:0] qtx[$], qwr[$], qdn[$];
  logic [7:0] mem [int];
  string s;
  tib_accept #(.TIB(TIB), .TIB_SZ(TSZ), .MSZ(8), .ASZ(17)) dut (
    .clk(clk), .rst(rst), .en_i(en_i), .rx_vld_i(rx_vld_i), .rx_dat_i(rx_dat_i),
    .rx_rdy_o(rx_rdy_o), .tx_vld_o(tx_vld_o), .tx_dat_o(tx_dat_o), .tx_rdy_i(tx_rdy_i),
    .mb_we_o(mb_we_o), .mb_ai_o(mb_ai_o), .mb_vi_o(mb_vi_o), .ack_i(ack_i),
    .done_o(done_o), .len_o(len_o), .ovf_o(ovf_o), .bsy_o(bsy_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (tx_vld_o && tx_rdy_i) begin
      if (qtx.size() != 0) chk("tx", tx_dat_o, qtx.pop_front());
      else chk("tx_extra", {24'b0, tx_dat_o}, 32'h100);
    end
    if (mb_we_o) begin
      mem[int'(mb_ai_o)] = mb_vi_o;
      if (qwr.size() != 0) chk("wr", {mb_ai_o, mb_vi_o}, qwr.pop_front());
      else chk("wr_extra", {15'b0, mb_ai_o}, 32'hffffffff);
    end
    if (done_o) begin
      if (qdn.size() != 0) chk("done_len", len_o, qdn.pop_front());
      else chk("done_extra", {24'b0, len_o}, 32'h100);
    end
  end
  task automatic model(input logic [7:0] b);
    logic [7:0] c;
    c = b == 8'h09 ? 8'h20 : b;
    if (c >= 8'h20 && c <= 8'h7e) begin
      if (m_len < TSZ - 2) begin
        qwr.push_back({7'b0, 17'(TIB + m_len), c});
        qtx.push_back({24'b0, c});
        m_len++;
      end else begin
        qtx.push_back(32'h07);
        m_ovf = 1;
      end
    end else if (b == 8'h08 || b == 8'h7f) begin
      if (m_len > 0) begin
        m_len--;
        qtx.push_back(32'h08);
        qtx.push_back(32'h20);
        qtx.push_back(32'h08);
      end
    end else if (b == 8'h0d || b == 8'h0a) begin
      qwr.push_back({7'b0, 17'(TIB + m_len), 8'h20});
      qwr.push_back({7'b0, 17'(TIB + m_len + 1), 8'h00});
      qdn.push_back(32'(m_len));
    end
  endtask
  task automatic send(input logic [7:0] b, input bit mdl);
    bit ok;
    ok = 0;
    if (mdl) model(b);
    rx_vld_i = 1;
    rx_dat_i = b;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = rx_rdy_o;
      @(posedge clk);
      #1;
    end
    rx_vld_i = 0;
    if (!ok) chk("rx_tmo", {31'b0, rx_rdy_o}, 32'h2);
  endtask
  task automatic sends(input string t);
    for (int i = 0; i < t.len(); i++) send(t[i], 1);
  endtask
  task automatic wait_q();
    for (int i = 0; i < 500 && (qtx.size() + qwr.size() + qdn.size()) != 0; i++) @(negedge clk);
    chk("drain", qtx.size() + qwr.size() + qdn.size(), 0);
    @(posedge clk);
    #1;
  endtask
  task automatic do_ack();
    ack_i = 1;
    @(posedge clk);
    #1;
    ack_i = 0;
    m_len = 0;
    m_ovf = 0;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_len", len_o, 0);
    chk("rst_ovf", ovf_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_rdy", rx_rdy_o, 0);
    chk("rst_txv", tx_vld_o, 0);
    chk("rst_txd", tx_dat_o, 0);
    chk("rst_we", mb_we_o, 0);
    chk("rst_ai", mb_ai_o, TIB);
    chk("rst_vi", mb_vi_o, 0);
    chk("rst_bsy", bsy_o, 0);
    rst = 0;
    en_i = 1;
    sends("1 2 +\r");
    wait_q();
    s = "1 2 + ";
    for (int i = 0; i < 6; i++) chk("t1_mem", mem[TIB + i], s[i]);
    chk("t1_nul", mem[TIB + 6], 0);
    chk("t1_len", len_o, 5);
    chk("t1_bsy", bsy_o, 1);
    do_ack();
    chk("t1_len_ack", len_o, 0);
    sends("AB");
    send(8'h08, 1);
    sends("C\r");
    wait_q();
    s = "AC ";
    for (int i = 0; i < 3; i++) chk("t2_mem", mem[TIB + i], s[i]);
    chk("t2_nul", mem[TIB + 3], 0);
    chk("t2_len", len_o, 2);
    do_ack();
    send(8'h08, 1);
    @(negedge clk);
    chk("t3_rdy1", rx_rdy_o, 0);
    chk("t3_txv", tx_vld_o, 0);
    @(negedge clk);
    chk("t3_rdy2", rx_rdy_o, 1);
    send(8'h01, 1);
    @(negedge clk);
    chk("t3_we", mb_we_o, 0);
    chk("t3_len", len_o, 0);
    sends("xxxxxxx\r");
    wait_q();
    for (int i = 0; i < 6; i++) chk("t4_mem", mem[TIB + i], 8'h78);
    chk("t4_sp", mem[TIB + 6], 8'h20);
    chk("t4_nul", mem[TIB + 7], 0);
    chk("t4_ovf", ovf_o, m_ovf);
    chk("t4_len", len_o, 6);
    do_ack();
    chk("t4_ovf_ack", ovf_o, 0);
    chk("t4_len_ack", len_o, 0);
    tx_rdy_i = 0;
    send("Q", 1);
    rx_vld_i = 1;
    rx_dat_i = "R";
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t5_txv", tx_vld_o, 1);
      chk("t5_txd", tx_dat_o, "Q");
      chk("t5_rdy", rx_rdy_o, 0);
    end
    @(posedge clk);
    #1;
    tx_rdy_i = 1;
    send("R", 1);
    send(8'h09, 1);
    send(8'h0a, 1);
    wait_q();
    chk("t5_tab", mem[TIB + 2], 8'h20);
    chk("t5_len", len_o, 3);
    do_ack();
    send("Z", 1);
    wait_q();
    send(8'h0d, 0);
    en_i = 0;
    @(negedge clk);
    chk("t6_we_en", mb_we_o, 0);
    @(posedge clk);
    #1;
    m_len = 0;
    chk("t6_bsy_en", bsy_o, 0);
    chk("t6_len_en", len_o, 0);
    repeat (4) @(negedge clk);
    chk("t6_done_en", done_o, 0);
    en_i = 1;
    sends("K\r");
    wait_q();
    chk("t6_hold", bsy_o, 1);
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    m_len = 0;
    m_ovf = 0;
    chk("t6_len_rst", len_o, 0);
    chk("t6_bsy_rst", bsy_o, 0);
    chk("t6_we_rst", mb_we_o, 0);
    chk("t6_done_rst", done_o, 0);
    sends("ok\r");
    wait_q();
    chk("t7_len", len_o, 2);
    do_ack();
    repeat (3) @(posedge clk);
    chk("end_q", qtx.size() + qwr.size() + qdn.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
